reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Sole owner of the register file write port. Arbitrates write-back requests from `REQ_COUNT` producers (ALU, load unit, multiply unit) with round-robin fairness and a valid/ready handshake, and registers the winning write onto `wr_en` / `wr_reg_index` / `wr_reg_data`. After reset it runs an initialization sequence that writes zero to every register, then releases `init_done`.

## Interface

Parameters:
- `REQ_COUNT`, default 3: number of write-back requesters; minimum 2.
- `REGISTER_WIDTH`, default 32: data width.
- `REG_INDEX_WIDTH`, default 5: register index width.
- `REGISTER_COUNT`, default 32: number of registers; equals 2^`REG_INDEX_WIDTH`.

Ports:
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `REQ_COUNT`: per-requester write request.
- `req_index`, input, `REQ_COUNT*REG_INDEX_WIDTH`: packed destination indices; requester i uses slice i.
- `req_data`, input, `REQ_COUNT*REGISTER_WIDTH`: packed write data; requester i uses slice i.
- `req_ready`, output, `REQ_COUNT`: one-hot grant. A transfer occurs when `req_valid[i] & req_ready[i]` at a rising edge.
- `wr_en`, output, 1: register-file write enable (registered).
- `wr_reg_index`, output, `REG_INDEX_WIDTH`: register-file write index (registered).
- `wr_reg_data`, output, `REGISTER_WIDTH`: register-file write data (registered).
- `init_done`, output, 1: high once initialization has completed (registered).

## Operation

- FSM states:
  - `INIT` (reset state). The counter `init_idx` starts at 1. Each cycle the block drives a write of zero to `init_idx` and increments it. After the write to `REGISTER_COUNT-1` it moves to `RUN`. All `req_ready` bits are 0 throughout `INIT`.
  - `RUN`. Round-robin arbitration. There is no exit except reset.
- Arbitration in `RUN`:
  - `req_ready` is combinational from `req_valid` and the pointer `rr_ptr`.
  - Search starts at `rr_ptr` and proceeds through ascending indices with wrap-around. The first valid requester is granted.
  - At most one `req_ready` bit is high. `req_ready` is all-zero when no `req_valid` bit is set.
  - After a grant to requester i, `rr_ptr` becomes (i+1) mod `REQ_COUNT`. With no grant, `rr_ptr` holds.
- Output register:
  - On a transfer, the output stage loads `wr_reg_index` and `wr_reg_data` from the granted slice.
  - `wr_en` is 1 unless the index is 0. A write to register 0 is still accepted (the requester is released) but `wr_en` is 0.
  - With no transfer, `wr_en` is 0 and index/data hold their previous values.
- Requesters must hold `req_valid`, index and data stable until granted. The arbiter never drops an asserted request.
- Reset value of every output:
  - `wr_en` = 0, `wr_reg_index` = 0, `wr_reg_data` = 0, `init_done` = 0, `req_ready` = 0.
  - Internal state: `rr_ptr` = 0, `init_idx` = 1, state = `INIT`.
- Reset asserted mid-`INIT` or mid-`RUN`: all state returns to reset values immediately. Any write already registered is cancelled because `wr_en` clears asynchronously. Initialization restarts from index 1.

## Timing

- During `INIT`, on cycle k after reset release (k = 0..`REGISTER_COUNT`-2), the registered outputs show `wr_en` = 1, `wr_reg_index` = k+1, `wr_reg_data` = 0.
- `INIT` lasts `REGISTER_COUNT-1` cycles. `init_done` rises on the edge where the output register is loaded with the last init write. The first `req_ready` can assert in that same cycle.
- Write-back latency:
  - A handshake at edge T produces `wr_en` / `wr_reg_index` / `wr_reg_data` valid during cycle T→T+1.
  - The register file captures the value at edge T+1.
  - Total latency from request to update: 2 edges.
- Throughput: one write per cycle. Under saturation, each of N persistent requesters is granted exactly once every N cycles.

## Structure

- Shared package `reg_file_pkg`: `REGISTER_WIDTH`, `REG_INDEX_WIDTH`, `REGISTER_COUNT`, and the FSM state enum (`INIT`, `RUN`).
- Sub-module `rr_arbiter`: a parameterized N-way combinational round-robin grant from (`req`, `ptr`) to one-hot `grant` plus encoded index. It is reusable for future read-port or memory arbitration.
- Top level owns the FSM, the init counter, the pointer update and the output register.

## Test plan

- Reset and init:
  - Release `rst_n` with all `req_valid` = 1.
  - Required: `req_ready` = 0 for 31 cycles, with writes of zero to indices 1..31 in order.
  - Required: `init_done` = 1 after the write to index 31. No write to index 0 ever appears.
- Single requester:
  - Requester 1 drives index 7, data 0xDEADBEEF in `RUN`.
  - Required: `req_ready` = 3'b010 in the same cycle; next cycle `wr_en` = 1, index 7, data 0xDEADBEEF.
- Saturation fairness:
  - All 3 requesters valid for 9 cycles, starting with `rr_ptr` = 0.
  - Required grant order: 0,1,2,0,1,2,0,1,2, with `wr_en` high in each following cycle.
- Pointer skip:
  - `rr_ptr` = 1, only requesters 0 and 2 valid.
  - Required: grant to 2, then 0. `rr_ptr` returns to 1.
- Register 0 write:
  - Requester 0 drives index 0, data 0x1234.
  - Required: `req_ready[0]` = 1, next cycle `wr_en` = 0.
- Reset mid-run:
  - Assert `rst_n` = 0 in the cycle after a grant.
  - Required: `wr_en` drops immediately, `init_done` = 0, and `INIT` restarts from index 1 after release.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// rtl/reg_wb_arbiter_pkg.sv - register-file geometry and write-back FSM state type
package reg_file_pkg;

    localparam int REGISTER_WIDTH  = 32;
    localparam int REG_INDEX_WIDTH = 5;
    localparam int REGISTER_COUNT  = 1 << REG_INDEX_WIDTH;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - write-back request bus and register-file write port
interface reg_wb_arbiter_if
    import reg_file_pkg::*;
#(
    parameter int REQ_COUNT       = 3,
    parameter int REGISTER_WIDTH  = reg_file_pkg::REGISTER_WIDTH,
    parameter int REG_INDEX_WIDTH = reg_file_pkg::REG_INDEX_WIDTH
);
    logic [REQ_COUNT-1:0]                 req_valid;
    logic [REQ_COUNT*REG_INDEX_WIDTH-1:0] req_index;
    logic [REQ_COUNT*REGISTER_WIDTH-1:0]  req_data;
    logic [REQ_COUNT-1:0]                 req_ready;
    logic                                 wr_en;
    logic [REG_INDEX_WIDTH-1:0]           wr_reg_index;
    logic [REGISTER_WIDTH-1:0]            wr_reg_data;
    logic                                 init_done;

    modport master (
        output req_valid, req_index, req_data,
        input  req_ready, wr_en, wr_reg_index, wr_reg_data, init_done
    );

    modport slave (
        input  req_valid, req_index, req_data,
        output req_ready, wr_en, wr_reg_index, wr_reg_data, init_done
    );

endinterface

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// rtl/reg_wb_arbiter_rr_arbiter.sv - N-way combinational round-robin grant
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [N-1:0] hi_req;

    // Requests at or above ptr win first; otherwise wrap to the lowest request.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        hi_req      = '0;
        for (int i = 0; i < N; i++) begin
            hi_req[i] = req[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && hi_req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(i);
                grant[i]    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(i);
                grant[i]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write-port owner: zero-fill init, then round-robin write-back
module reg_wb_arbiter
    import reg_file_pkg::*;
#(
    parameter int REQ_COUNT       = 3,
    parameter int REGISTER_WIDTH  = reg_file_pkg::REGISTER_WIDTH,
    parameter int REG_INDEX_WIDTH = reg_file_pkg::REG_INDEX_WIDTH,
    parameter int REGISTER_COUNT  = reg_file_pkg::REGISTER_COUNT
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_wb_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(REQ_COUNT);

    wb_state_t                  state;
    wb_state_t                  state_next;
    logic [REG_INDEX_WIDTH-1:0] init_idx;
    logic [PTR_W-1:0]           rr_ptr;
    logic [REQ_COUNT-1:0]       grant;
    logic [PTR_W-1:0]           grant_idx;
    logic                       grant_valid;
    logic                       transfer;
    logic                       init_last;
    logic [REG_INDEX_WIDTH-1:0] sel_index;
    logic [REGISTER_WIDTH-1:0]  sel_data;

    rr_arbiter #(
        .N  (REQ_COUNT),
        .IW (PTR_W)
    ) u_rr_arbiter (
        .req         (bus.req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign init_last = (init_idx == REG_INDEX_WIDTH'(REGISTER_COUNT - 1));
    assign sel_index = bus.req_index[int'(grant_idx)*REG_INDEX_WIDTH +: REG_INDEX_WIDTH];
    assign sel_data  = bus.req_data[int'(grant_idx)*REGISTER_WIDTH +: REGISTER_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        transfer      = 1'b0;
        case (state)
            INIT: begin
                if (init_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.req_ready = grant;
                transfer      = grant_valid;
            end
        endcase
    end

    // Register 0 is hardwired zero: its writes are accepted but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en        <= 1'b0;
            bus.wr_reg_index <= '0;
            bus.wr_reg_data  <= '0;
            bus.init_done    <= 1'b0;
            init_idx         <= REG_INDEX_WIDTH'(1);
            rr_ptr           <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                INIT: begin
                    bus.wr_en        <= 1'b1;
                    bus.wr_reg_index <= init_idx;
                    bus.wr_reg_data  <= '0;
                    init_idx         <= init_idx + 1'b1;
                    if (init_last) begin
                        bus.init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (transfer) begin
                        bus.wr_en        <= (sel_index != '0);
                        bus.wr_reg_index <= sel_index;
                        bus.wr_reg_data  <= sel_data;
                        rr_ptr           <= (grant_idx == PTR_W'(REQ_COUNT - 1)) ? '0
                                                                                  : grant_idx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - scoreboard bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int IW = 5;
    localparam int RC = 32;

    typedef struct packed {
        logic          we;
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_wb_arbiter_if #(.REQ_COUNT(N), .REGISTER_WIDTH(W), .REG_INDEX_WIDTH(IW)) bus ();

    reg_wb_arbiter #(
        .REQ_COUNT       (N),
        .REGISTER_WIDTH  (W),
        .REG_INDEX_WIDTH (IW),
        .REGISTER_COUNT  (RC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wr_t           exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    bit            pend[N];
    logic [IW-1:0] p_idx[N];
    logic [W-1:0]  p_data[N];
    int            model_ptr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first pending requester at or after the pointer, wrapping.
    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic add(input int i, input logic [IW-1:0] idx, input logic [W-1:0] d);
        pend[i]   = 1'b1;
        p_idx[i]  = idx;
        p_data[i] = d;
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = pend[i];
            bus.req_index[i*IW +: IW] = p_idx[i];
            bus.req_data[i*W +: W]    = p_data[i];
        end
    endtask

    // One bus cycle, entered and left at posedge+1. want = -2 uses the model's choice.
    task automatic step(input int want);
        int           g;
        logic [N-1:0] er;
        wr_t          e;
        #1;
        drive_bus();
        g  = (want == -2) ? model_pick() : want;
        er = (g >= 0) ? N'(1 << g) : '0;
        @(negedge clk);
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        if (g >= 0) begin
            e.we   = (p_idx[g] != '0);
            e.idx  = p_idx[g];
            e.data = p_data[g];
            exp_q.push_back(e);
            pend[g]   = 1'b0;
            model_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    // Expects rst_n low on entry; leaves at posedge+1 with init_done just set.
    task automatic init_seq();
        mon_en    = 1'b0;
        model_ptr = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            p_idx[i]  = IW'(i + 3);
            p_data[i] = $urandom;
            bus.req_index[i*IW +: IW] = p_idx[i];
            bus.req_data[i*W +: W]    = p_data[i];
        end
        bus.req_valid = '1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < RC - 1; k++) begin
            chk("init_ready", 64'(bus.req_ready), 64'd0);
            @(posedge clk);
            #1;
            chk("init_wr_en", 64'(bus.wr_en), 64'd1);
            chk("init_index", 64'(bus.wr_reg_index), 64'(k + 1));
            chk("init_data", 64'(bus.wr_reg_data), 64'd0);
            chk("init_done", 64'(bus.init_done), 64'(k == RC - 2));
            if (k < RC - 2) @(negedge clk);
        end
        bus.req_valid = '0;
        mon_en = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            bit  hs;
            bit  en;
            wr_t e;
            @(negedge clk);
            hs = |(bus.req_valid & bus.req_ready);
            en = mon_en;
            @(posedge clk);
            #1;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transfer: got ready %0b with no expected write at %0t",
                             bus.req_ready, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_en", 64'(bus.wr_en), 64'(e.we));
                    chk("wr_reg_index", 64'(bus.wr_reg_index), 64'(e.idx));
                    chk("wr_reg_data", 64'(bus.wr_reg_data), 64'(e.data));
                end
            end else if (en) begin
                chk("wr_en_idle", 64'(bus.wr_en), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        bus.req_valid = '0;
        bus.req_index = '0;
        bus.req_data  = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_index", 64'(bus.wr_reg_index), 64'd0);
        chk("rst_data", 64'(bus.wr_reg_data), 64'd0);
        chk("rst_init_done", 64'(bus.init_done), 64'd0);
        init_seq();

        add(1, 5'd7, 32'hDEADBEEF);
        step(1);
        step(-1);

        add(0, 5'd0, 32'h1234);
        step(0);
        step(-1);

        add(0, 5'd3, 32'hA0A0A0A0);
        add(2, 5'd4, 32'h0B0B0B0B);
        step(2);
        step(0);
        add(0, 5'd5, 32'h11111111);
        add(1, 5'd6, 32'h22222222);
        step(1);
        step(0);

        add(2, 5'd8, 32'h33333333);
        step(2);
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) add(i, IW'($urandom_range(1, RC - 1)), $urandom);
            end
            step(c % 3);
        end

        repeat (300) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    add(i, ($urandom_range(0, 7) == 0) ? IW'(0) : IW'($urandom_range(1, RC - 1)),
                        $urandom);
                end
            end
            step(-2);
        end
        for (int d = 0; d < N + 1; d++) step(-2);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        add(1, 5'd9, 32'hCAFEF00D);
        step(-2);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("midrun_wr_en", 64'(bus.wr_en), 64'd0);
        chk("midrun_init_done", 64'(bus.init_done), 64'd0);
        chk("midrun_ready", 64'(bus.req_ready), 64'd0);
        init_seq();

        add(0, 5'd10, 32'h44444444);
        add(1, 5'd11, 32'h55555555);
        add(2, 5'd12, 32'h66666666);
        step(0);
        step(1);
        step(2);
        step(-1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
